// File: rtl/e4m4_9b_to_q6_11.sv
// ---------------------------------------------------------------------------
// e4m4_9b_to_q6_11
//   Converts a 9-bit E4M4 float (sign, 4-bit exponent, 4-bit mantissa,
//   bias 8, no subnormals) to an 18-bit signed Q6.11 fixed-point value.
//   It sits between the compact-float weight/activation store and the
//   fixed-point MAC array. A combinational decode feeds a single output
//   register stage.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   fp carries a value this cycle
//   fp         in   9   [8]=sign, [7:4]=exponent, [3:0]=mantissa
//   out_valid  out  1   q/ovf updated this cycle (in_valid delayed by 1)
//   q          out  18  Q6.11 result, two's complement, wraps modulo 2^18
//   ovf        out  1   true value not representable in 18-bit signed
// ---------------------------------------------------------------------------
module e4m4_9b_to_q6_11 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [8:0]  fp,
  output logic        out_valid,
  output logic [17:0] q,
  output logic        ovf
);

  // Largest magnitudes representable in 18-bit two's complement.
  localparam logic [19:0] MAX_POS_MAG = 20'd131071;
  localparam logic [19:0] MAX_NEG_MAG = 20'd131072;

  logic        sign;
  logic [3:0]  expo;
  logic [3:0]  mant;
  logic [3:0]  shamt;
  logic [19:0] mag;
  logic [19:0] q_full;
  logic        ovf_calc;

  logic        out_valid_d, out_valid_q;
  logic [17:0] q_d,         q_q;
  logic        ovf_d,       ovf_q;

  assign sign = fp[8];
  assign expo = fp[7:4];
  assign mant = fp[3:0];

  // Decode. Value*2048 = (16+m) * 2^(e-1), an exact integer of at most
  // 19 bits, so a 20-bit datapath holds the magnitude and its negation.
  // NOTE: every signal written in always_comb receives a value on every
  // path (defaults first); otherwise synthesis infers a latch.
  always_comb begin
    shamt    = 4'd0;
    mag      = 20'd0;
    q_full   = 20'd0;
    ovf_calc = 1'b0;
    if (expo != 4'd0) begin
      shamt  = expo - 4'd1;
      mag    = 20'({1'b1, mant}) << shamt;
      q_full = sign ? (~mag + 20'd1) : mag;
      // The negative range reaches one step further than the positive one.
      ovf_calc = sign ? (mag > MAX_NEG_MAG) : (mag > MAX_POS_MAG);
    end
  end

  // Next-state: results load only on a valid input and hold otherwise.
  always_comb begin
    out_valid_d = in_valid;
    q_d         = q_q;
    ovf_d       = ovf_q;
    if (in_valid) begin
      q_d   = q_full[17:0];   // modulo 2^18 wrap, no saturation
      ovf_d = ovf_calc;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      q_q         <= 18'd0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      q_q         <= q_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign q         = q_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_e4m4_9b_to_q6_11.sv
// ---------------------------------------------------------------------------
// tb_e4m4_9b_to_q6_11
//   Self-checking bench for e4m4_9b_to_q6_11. Expected results are pushed
//   to a scoreboard queue when stimulus is driven and compared when the
//   DUT raises out_valid. Golden values come from a real-number model of
//   the float value scaled by 2048.
// ---------------------------------------------------------------------------
module tb_e4m4_9b_to_q6_11;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [8:0]  fp;
  logic        out_valid;
  logic [17:0] q;
  logic        ovf;

  e4m4_9b_to_q6_11 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .fp        (fp),
    .out_valid (out_valid),
    .q         (q),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] q;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [8:0] fp;
    int         q;
    logic       ovf;
  } vec_t;

  exp_t        sb[$];
  vec_t        tbl[13];
  int          n_pass  = 0;
  int          n_total = 0;
  logic [17:0] last_q  = 18'd0;
  logic        last_ovf = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Independent model: evaluate the float as a real and scale by 2048.
  function automatic exp_t golden(input logic [8:0] f);
    exp_t   r;
    int     e;
    int     m;
    real    v;
    longint t;
    logic [63:0] tb;
    e = int'(f[7:4]);
    m = int'(f[3:0]);
    r.q   = 18'd0;
    r.ovf = 1'b0;
    if (e != 0) begin
      v = (1.0 + m / 16.0) * $pow(2.0, e - 8) * 2048.0;
      t = longint'(v);
      if (f[8]) t = -t;
      r.ovf = (t > 131071) || (t < -131072);
      tb  = 64'(t);
      r.q = tb[17:0];
    end
    return r;
  endfunction

  task automatic drive(input logic v, input logic [8:0] f, input exp_t e);
    @(posedge clk);
    #1;
    in_valid = v;
    fp       = f;
    if (v) sb.push_back(e);
  endtask

  // Scoreboard consumer: compare every valid output against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("q", longint'(q), longint'(e.q));
        check("ovf", longint'(ovf), longint'(e.ovf));
        last_q   = e.q;
        last_ovf = e.ovf;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    tbl[0]  = '{9'h080,    2048, 1'b0};
    tbl[1]  = '{9'h188,   -3072, 1'b0};
    tbl[2]  = '{9'h000,       0, 1'b0};
    tbl[3]  = '{9'h00F,       0, 1'b0};
    tbl[4]  = '{9'h100,       0, 1'b0};
    tbl[5]  = '{9'h10F,       0, 1'b0};
    tbl[6]  = '{9'h010,      16, 1'b0};
    tbl[7]  = '{9'h01F,      31, 1'b0};
    tbl[8]  = '{9'h11F,     -31, 1'b0};
    tbl[9]  = '{9'h0DF,  126976, 1'b0};
    tbl[10] = '{9'h0E0, -131072, 1'b1};
    tbl[11] = '{9'h1E0, -131072, 1'b0};
    tbl[12] = '{9'h0FF,  -16384, 1'b1};

    // Reset state, visible before any clock edge.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    fp       = 9'h1AB;
    #2;
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_q", longint'(q), 0);
    check("reset_ovf", longint'(ovf), 0);
    in_valid = 1'b0;
    #10 rst_n = 1'b1;
    @(negedge clk);
    check("idle_out_valid", longint'(out_valid), 0);

    // Directed table, back to back.
    for (int i = 0; i < 13; i++) begin
      e.q   = 18'(tbl[i].q);
      e.ovf = tbl[i].ovf;
      drive(1'b1, tbl[i].fp, e);
    end

    // Exhaustive sweep, back to back.
    for (int i = 0; i < 512; i++) begin
      drive(1'b1, 9'(i), golden(9'(i)));
    end

    // in_valid low: out_valid drops, q/ovf hold the last result.
    e = golden(9'h080);
    drive(1'b0, 9'h080, e);
    repeat (3) @(negedge clk);
    check("hold_out_valid", longint'(out_valid), 0);
    check("hold_q", longint'(q), longint'(last_q));
    check("hold_ovf", longint'(ovf), longint'(last_ovf));
    check("drain_sweep", longint'(sb.size()), 0);

    // Reset mid-stream: outputs clear without waiting for a clock.
    drive(1'b1, 9'h0A5, golden(9'h0A5));
    drive(1'b1, 9'h0FF, golden(9'h0FF));
    drive(1'b1, 9'h1C3, golden(9'h1C3));
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midreset_out_valid", longint'(out_valid), 0);
    check("midreset_q", longint'(q), 0);
    check("midreset_ovf", longint'(ovf), 0);
    sb.delete();
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_reset_idle", longint'(out_valid), 0);
    end

    // First out_valid after release follows the next in_valid by one cycle.
    drive(1'b1, 9'h188, golden(9'h188));
    @(negedge clk);
    check("first_valid_not_early", longint'(out_valid), 0);
    drive(1'b0, 9'h000, golden(9'h000));
    #3;
    check("first_valid_on_time", longint'(out_valid), 1);
    repeat (3) @(negedge clk);
    check("drain_final", longint'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
